// File: rtl/regfile_dump_ctrl.sv
// Debug read-out engine: on start, walks the register file one index per beat and
// streams each word over valid/ready. Define REGFILE_DUMP_CSUM_EN for a trailing XOR beat.
module regfile_dump_ctrl #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rf_addr_o,
    input  logic [DATA_W-1:0] rf_rdata_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [ADDR_W-1:0] out_idx_o,
    output logic              out_last_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_REGS - 1);

`ifdef REGFILE_DUMP_CSUM_EN
    typedef enum logic [2:0] {StIdle, StFetch, StSend, StDone, StCsum} state_e;
`else
    typedef enum logic [2:0] {StIdle, StFetch, StSend, StDone} state_e;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] oidx_q, oidx_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;
`ifdef REGFILE_DUMP_CSUM_EN
    logic [DATA_W-1:0] acc_q, acc_d;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        oidx_d  = oidx_q;
        last_d  = last_q;
        valid_d = valid_q;
`ifdef REGFILE_DUMP_CSUM_EN
        acc_d   = acc_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFetch;
                    idx_d   = '0;
`ifdef REGFILE_DUMP_CSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            StFetch: begin
                data_d  = rf_rdata_i;
                oidx_d  = idx_q;
                valid_d = 1'b1;
`ifdef REGFILE_DUMP_CSUM_EN
                last_d  = 1'b0;
                acc_d   = acc_q ^ rf_rdata_i;
`else
                last_d  = (idx_q == LastIdx);
`endif
                state_d = StSend;
            end
            StSend: begin
                if (out_ready_i) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (idx_q == LastIdx) begin
`ifdef REGFILE_DUMP_CSUM_EN
                        // Checksum beat is loaded here so it is presented with no bubble.
                        data_d  = acc_q;
                        oidx_d  = '1;
                        last_d  = 1'b1;
                        valid_d = 1'b1;
                        state_d = StCsum;
`else
                        state_d = StDone;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StFetch;
                    end
                end
            end
`ifdef REGFILE_DUMP_CSUM_EN
            StCsum: begin
                if (out_ready_i) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = StDone;
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            data_q  <= '0;
            oidx_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef REGFILE_DUMP_CSUM_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            oidx_q  <= oidx_d;
            last_q  <= last_d;
            valid_q <= valid_d;
`ifdef REGFILE_DUMP_CSUM_EN
            acc_q   <= acc_d;
`endif
        end
    end

    // idx only moves on entry to FETCH, so it also holds the last driven address elsewhere.
    assign rf_addr_o   = idx_q;
    assign out_data_o  = data_q;
    assign out_idx_o   = oidx_q;
    assign out_last_o  = last_q;
    assign out_valid_o = valid_q;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);

endmodule
